// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared types, defaults and one-hot decode for the AER root transmitter
package aer_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_ADDR_W     = 8;
  localparam int MAX_N          = 2 ** MAX_ADDR_W;

  typedef enum logic [1:0] {C_IDLE, C_ACK, C_REL} cap_state_e;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] idx;
  } onehot_dec_t;

  // valid only when exactly one bit is set; idx is the position of the highest set bit
  function automatic onehot_dec_t onehot_to_bin(input logic [MAX_N-1:0] vec);
    onehot_dec_t r;
    int unsigned ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) begin
        ones  = ones + 1;
        r.idx = MAX_ADDR_W'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/aer_root_tx_if.sv
// rtl/aer_root_tx_if.sv - arbiter-side and off-chip AER handshake bundle
interface aer_root_tx_if #(
  parameter int ADDR_W = 4
);
  localparam int N = 2 ** ADDR_W;

  logic              root_req;
  logic              root_ack_n;
  logic [N-1:0]      leaf_grant;
  logic              aer_req;
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_ack;

  modport master (
    input  root_req, leaf_grant, aer_ack,
    output root_ack_n, aer_req, aer_addr
  );

  modport slave (
    output root_req, leaf_grant, aer_ack,
    input  root_ack_n, aer_req, aer_addr
  );
endinterface

// File: rtl/aer_sync_ff.sv
// rtl/aer_sync_ff.sv - multi-flop single-bit synchronizer, resets to 0
module aer_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aer_root_tx.sv
// rtl/aer_root_tx.sv - arbiter root capture, event FIFO and 4-phase AER transmitter
module aer_root_tx
  import aer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  aer_root_tx_if.master               bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        grant_err
);

  localparam int N     = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              root_req_s, aer_ack_s;
  logic [N-1:0]      leaf_grant_s;

  aer_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (.clk(clk), .rst_n(rst_n), .d(bus.root_req), .q(root_req_s));
  aer_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (.clk(clk), .rst_n(rst_n), .d(bus.aer_ack),  .q(aer_ack_s));

  for (genvar g = 0; g < N; g++) begin : g_grant_sync
    aer_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(bus.leaf_grant[g]), .q(leaf_grant_s[g]));
  end

  cap_state_e        cap_state_q, cap_state_d;
  tx_state_e         tx_state_q, tx_state_d;
  logic              root_ack_n_q, root_ack_n_d;
  logic              grant_err_q, grant_err_d;
  logic [N-1:0]      grant_prev_q, grant_prev_d;
  logic              aer_req_q, aer_req_d;
  logic [ADDR_W-1:0] aer_addr_q, aer_addr_d;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [MAX_N-1:0]  grant_ext;
  onehot_dec_t       dec;

  // capture: a grant is trusted only after two identical synchronized samples
  always_comb begin
    cap_state_d  = cap_state_q;
    root_ack_n_d = root_ack_n_q;
    grant_err_d  = grant_err_q;
    grant_prev_d = leaf_grant_s;
    push         = 1'b0;
    push_addr    = '0;
    grant_ext    = '0;
    grant_ext[N-1:0] = leaf_grant_s;
    dec          = onehot_to_bin(grant_ext);
    case (cap_state_q)
      C_IDLE: if (root_req_s && cnt_q < CNT_W'(FIFO_DEPTH)) begin
        cap_state_d  = C_ACK;
        root_ack_n_d = 1'b0;
      end
      C_ACK: if (leaf_grant_s != '0 && leaf_grant_s == grant_prev_q) begin
        cap_state_d = C_REL;
        if (dec.valid && int'(dec.idx) < N) begin
          push      = 1'b1;
          push_addr = dec.idx[ADDR_W-1:0];
        end else begin
          grant_err_d = 1'b1;
        end
      end
      C_REL: if (!root_req_s) begin
        cap_state_d  = C_IDLE;
        root_ack_n_d = 1'b1;
      end
      default: begin
        cap_state_d  = C_IDLE;
        root_ack_n_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    aer_req_d  = aer_req_q;
    aer_addr_d = aer_addr_q;
    pop        = 1'b0;
    case (tx_state_q)
      T_IDLE: if (cnt_q != '0) begin
        aer_addr_d = mem_q[rd_ptr_q];
        aer_req_d  = 1'b1;
        tx_state_d = T_REQ;
      end
      T_REQ: if (aer_ack_s) begin
        aer_req_d  = 1'b0;
        pop        = 1'b1;
        tx_state_d = T_REL;
      end
      T_REL: if (!aer_ack_s) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // a push never overflows: the capture side only acknowledges with a free slot
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    if (push) mem_d[wr_ptr_q] = push_addr;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_q  <= C_IDLE;
      tx_state_q   <= T_IDLE;
      root_ack_n_q <= 1'b1;
      grant_err_q  <= 1'b0;
      grant_prev_q <= '0;
      aer_req_q    <= 1'b0;
      aer_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cap_state_q  <= cap_state_d;
      tx_state_q   <= tx_state_d;
      root_ack_n_q <= root_ack_n_d;
      grant_err_q  <= grant_err_d;
      grant_prev_q <= grant_prev_d;
      aer_req_q    <= aer_req_d;
      aer_addr_q   <= aer_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.root_ack_n = root_ack_n_q;
  assign bus.aer_req    = aer_req_q;
  assign bus.aer_addr   = aer_addr_q;
  assign fifo_cnt       = cnt_q;
  assign grant_err      = grant_err_q;

endmodule

// File: tb/tb_aer_root_tx.sv
// tb/tb_aer_root_tx.sv - randomized self-checking bench for aer_root_tx against an event-queue model
module tb_aer_root_tx;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fifo_cnt;
  logic       grant_err;

  aer_root_tx_if #(.ADDR_W(ADDR_W)) bus ();

  aer_root_tx #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .fifo_cnt(fifo_cnt), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  bit rx_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one arbiter-tree handshake; a one-hot grant is an event the receiver must later see
  task automatic send_event(input logic [15:0] grant, input bit chk_lat, input bit glitch);
    int k;
    bus.root_req = 1'b1;
    k = 0;
    while (bus.root_ack_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk("ack_fall", bus.root_ack_n, 1'b0);
    if (chk_lat) chk("ack_latency", k, SYNC + 1);
    if (glitch) begin
      bus.leaf_grant = 16'h0001; @(negedge clk);
      bus.leaf_grant = 16'h0003; @(negedge clk);
    end
    bus.leaf_grant = grant;
    if ($countones(grant) == 1) exp_q.push_back($clog2(grant));
    repeat (6) @(negedge clk);
    bus.root_req   = 1'b0;
    bus.leaf_grant = '0;
    k = 0;
    while (bus.root_ack_n !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("ack_rise", bus.root_ack_n, 1'b1);
  endtask

  task automatic man_ack();
    int k;
    k = 0;
    while (bus.aer_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("man_req", bus.aer_req, 1'b1);
    chk("man_addr", bus.aer_addr, exp_q.pop_front());
    bus.aer_ack = 1'b1;
    k = 0;
    while (bus.aer_req !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    chk("man_req_fall", bus.aer_req, 1'b0);
    bus.aer_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    rx_en = 1'b1;
    k = 0;
    while ((fifo_cnt != 0 || bus.aer_req || bus.aer_ack) && k < 400) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("drain_cnt", fifo_cnt, 0);
    chk("drain_model", exp_q.size(), 0);
  endtask

  // off-chip receiver: random ack delays, address compared with the model queue head
  initial begin
    int k;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (rx_en && bus.aer_req === 1'b1 && bus.aer_ack === 1'b0) begin
        a = bus.aer_addr;
        if (exp_q.size() == 0) chk("rx_spurious", exp_q.size(), 1);
        else chk("rx_addr", a, exp_q.pop_front());
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.aer_ack = 1'b1;
        k = 0;
        while (bus.aer_req === 1'b1 && k < 50) begin
          chk("rx_addr_stable", bus.aer_addr, a);
          @(negedge clk); k++;
        end
        chk("rx_req_fall", bus.aer_req, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.aer_ack = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic [15:0] g;
    rst_n = 1'b0;
    bus.root_req = 1'b0; bus.leaf_grant = '0; bus.aer_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack_n", bus.root_ack_n, 1'b1);
    chk("rst_req", bus.aer_req, 1'b0);
    chk("rst_addr", bus.aer_addr, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_err", grant_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    rx_en = 1'b1;
    send_event(16'h0020, 1'b1, 1'b0);
    drain();

    send_event(16'h0002, 1'b1, 1'b1);
    drain();
    chk("glitch_err", grant_err, 1'b0);

    // back-pressure: fill four slots with the receiver stalled
    rx_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_event(16'h1 << (i * 3 + 1), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("bp_full", fifo_cnt, DEPTH);
    bus.root_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_no_ack", bus.root_ack_n, 1'b1);
    chk("bp_cnt_hold", fifo_cnt, DEPTH);
    man_ack();
    send_event(16'h8000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("bp_refill", fifo_cnt, DEPTH);
    drain();

    // push and pop land on the same edge at occupancy 2
    rx_en = 1'b0;
    send_event(16'h0400, 1'b1, 1'b0);
    send_event(16'h0008, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pp_cnt0", fifo_cnt, 2);
    chk("pp_req", bus.aer_req, 1'b1);
    chk("pp_head", bus.aer_addr, exp_q[0]);
    bus.root_req = 1'b1;
    k = 0;
    while (bus.root_ack_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    chk("pp_ack_fall", bus.root_ack_n, 1'b0);
    bus.leaf_grant = 16'h2000;
    exp_q.push_back(13);
    @(negedge clk);
    bus.aer_ack = 1'b1;
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pp_cnt", fifo_cnt, 2);
    end
    chk("pp_req_fall", bus.aer_req, 1'b0);
    bus.root_req = 1'b0; bus.leaf_grant = '0; bus.aer_ack = 1'b0;
    k = 0;
    while (bus.root_ack_n !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("pp_ack_rise", bus.root_ack_n, 1'b1);
    drain();

    for (int i = 0; i < 14; i++) begin
      g = 16'h1 << $urandom_range(0, 15);
      send_event(g, 1'b0, 1'b0);
    end
    drain();

    send_event(16'h0006, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("bad_err", grant_err, 1'b1);
    chk("bad_no_push", fifo_cnt, 0);

    // reset while the capture side is in C_REL and the link is requesting
    rx_en = 1'b0;
    bus.root_req = 1'b1;
    k = 0;
    while (bus.root_ack_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    chk("rr_ack_fall", bus.root_ack_n, 1'b0);
    bus.leaf_grant = 16'h0010;
    repeat (8) @(negedge clk);
    chk("rr_req", bus.aer_req, 1'b1);
    chk("rr_ack_low", bus.root_ack_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rr_ack_n", bus.root_ack_n, 1'b1);
    chk("rr_aer_req", bus.aer_req, 1'b0);
    chk("rr_cnt", fifo_cnt, 0);
    chk("rr_addr", bus.aer_addr, 0);
    chk("rr_err", grant_err, 1'b0);
    bus.root_req = 1'b0; bus.leaf_grant = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rx_en = 1'b1;
    send_event(16'h0200, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aer_root_tx.md
# aer_root_tx

Clocked transmit stage at the root of the asynchronous spike-encoder arbiter tree. It synchronizes the root request, returns the active-low root acknowledge, and captures the one-hot leaf grant as a binary neuron address. The address goes into a small FIFO and out over a 4-phase AER req/ack link to the off-chip receiver. The FIFO gives backpressure only: a request is never acknowledged without a free slot, so no event is lost.

## Interface
- ADDR_W, 4: address width; number of leaves N = 2**ADDR_W.
- FIFO_DEPTH, 4: event FIFO entries, power of two, ≥2.
- SYNC_STAGES, 2: flops per synchronizer, ≥2.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- root_req  in  1  root request from top arbiter (async, active-high).
- root_ack_n  out  1  acknowledge into top arbiter request/ack input, active-low.
- leaf_grant  in  N  one-hot leaf acknowledges (async, active-high, inverted leaf ack outputs).
- aer_req  out  1  off-chip event request, active-high.
- aer_addr  out  ADDR_W  event address, stable while aer_req=1.
- aer_ack  in  1  off-chip acknowledge (async).
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  current occupancy.
- grant_err  out  1  sticky: captured grant not one-hot.

## Operation
- All async inputs (root_req, aer_ack, each leaf_grant bit) pass through SYNC_STAGES flops before use. The suffix _s below means the synchronized value.
- Capture FSM, states C_IDLE, C_ACK, C_REL:
  - C_IDLE: if root_req_s=1 and fifo_cnt<FIFO_DEPTH, go to C_ACK and drive root_ack_n=0.
  - C_IDLE, FIFO full: stay in C_IDLE and keep root_ack_n=1.
  - C_ACK: hold root_ack_n=0. Once leaf_grant_s is nonzero and equal to its previous-cycle value, decide:
    - exactly one bit set: push its binary index and go to C_REL.
    - otherwise: set grant_err, push nothing, go to C_REL.
  - C_REL: hold root_ack_n=0 until root_req_s=0. Then set root_ack_n=1 and go to C_IDLE.
- TX FSM, states T_IDLE, T_REQ, T_REL:
  - T_IDLE: if FIFO is non-empty, load aer_addr from head, set aer_req=1, go to T_REQ.
  - T_REQ: on aer_ack_s=1, clear aer_req, pop head, go to T_REL.
  - T_REL: on aer_ack_s=0, go to T_IDLE.
- FIFO: circular, pointers ADDR wrap modulo FIFO_DEPTH. Count width carries the extra bit so full (cnt=FIFO_DEPTH) is distinct from empty.
- Push and pop in the same cycle: both occur; count unchanged. This is legal even at full, because the full check happened at C_IDLE exit.
- grant_err is cleared only by reset.

## Timing
- Reset values: root_ack_n=1, aer_req=0, aer_addr=0, fifo_cnt=0, grant_err=0. FSMs reset to C_IDLE and T_IDLE, pointers to 0, synchronizers to 0.
- Reset mid-handshake: all outputs return to reset values immediately (asynchronous); the FIFO content is discarded. The arbiter tree sees the ack released and retracts normally.
- root_ack_n falls SYNC_STAGES+1 cycles after root_req rises (FIFO not full).
- Push occurs SYNC_STAGES+2 cycles minimum after root_ack_n falls (grant sync plus one stability cycle).
- aer_req rises the cycle after fifo_cnt becomes non-zero. Registered outputs only, no combinational path from inputs to outputs.
- aer_addr changes only in T_IDLE while aer_req=0.
- Back-to-back events: the next root_ack_n fall comes no earlier than SYNC_STAGES+1 cycles after root_ack_n rose.

## Structure
- Shared package aer_pkg: capture and TX state enums, default ADDR_W/FIFO_DEPTH constants, and a onehot-to-binary function with a one-hot validity flag.
- One sub-module, aer_sync_ff: a parameterized SYNC_STAGES bit synchronizer with async active-low reset to 0. Instantiate it per async bit.
- Keep the FIFO inline.

## Test plan
- Single event: root_req=1, leaf_grant=16'h0020 after ack → aer_addr=5 with aer_req=1; ack cycle → aer_req=0, fifo_cnt back to 0.
- Back-pressure: hold aer_ack=0 and send 5 events with FIFO_DEPTH=4 → four pushes, fifo_cnt=4. The 5th root_req gets no root_ack_n=0 until one aer_ack completes; then the 5th is accepted; addresses exit in order.
- Bad grant: leaf_grant=16'h0006 stable → grant_err=1, no push, root_ack_n still releases after root_req falls.
- Simultaneous push/pop at fifo_cnt=2 → fifo_cnt stays 2, addresses preserved in order across pointer wrap (≥9 events total).
- Glitchy grant: leaf_grant toggles 0x1→0x3→0x2 then stays 0x2 → captured address 1 only after two equal synchronized samples, grant_err=0.
- Reset asserted in C_REL with aer_req=1 → root_ack_n=1, aer_req=0, fifo_cnt=0 in the same cycle, clean restart afterwards.
